// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared bus operation and sequencer state types
package bus_pkg;

  typedef enum logic [1:0] {
    MEM_RD = 2'd0,
    MEM_WR = 2'd1,
    IO_RD  = 2'd2,
    IO_WR  = 2'd3
  } bus_op_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_HOLD = 3'd4
  } bus_state_t;

  function automatic logic op_is_io(input bus_op_t op);
    return op[1];
  endfunction

  function automatic logic op_is_write(input bus_op_t op);
    return op[0];
  endfunction

endpackage

// File: rtl/bus_cmd_fifo.sv
// rtl/bus_cmd_fifo.sv - synchronous command FIFO with wrap-bit pointers
module bus_cmd_fifo #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Flags come from registered pointers only, so a push into an empty FIFO
  // cannot be popped the same cycle and a pop from a full one frees its
  // slot only from the next cycle.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/bus_seq_master.sv
// rtl/bus_seq_master.sv - queued Z80-style bus master with wait states and bus hand-over
module bus_seq_master
  import bus_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int CMD_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  idle,
  output logic                  iorq_n_,
  output logic                  mreq_n_,
  output logic                  rd_n_,
  output logic                  wr_n_,
  output logic [ADDR_WIDTH-1:0] addr_,
  inout  wire  [DATA_WIDTH-1:0] data_,
  input  logic                  buswait_n,
  input  logic                  busrq_n,
  output logic                  busack_n_
);

  typedef struct packed {
    bus_op_t               op;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } bus_cmd_t;

  localparam int CMD_W = $bits(bus_cmd_t);

  bus_state_t            state;
  bus_op_t               op_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  iorq_q;
  logic                  mreq_q;
  logic                  rd_q;
  logic                  wr_q;
  logic                  busack_q;
  logic                  master;

  bus_cmd_t              cmd_in;
  bus_cmd_t              head;
  logic [CMD_W-1:0]      fifo_rd;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_pop;

  assign cmd_in.op   = bus_op_t'(cmd_op);
  assign cmd_in.addr = cmd_addr;
  assign cmd_in.data = cmd_data;
  assign head        = bus_cmd_t'(fifo_rd);

  assign cmd_ready = reset_n && !fifo_full;
  assign fifo_pop  = (state == S_IDLE) && busrq_n && !fifo_empty;
  assign idle      = reset_n && fifo_empty && (state == S_IDLE);

  bus_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (CMD_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (cmd_valid && cmd_ready),
    .push_data (cmd_in),
    .pop       (fifo_pop),
    .pop_data  (fifo_rd),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Strobes are registered alongside the state so the pins never glitch.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      op_q      <= MEM_RD;
      addr_q    <= '0;
      wdata_q   <= '0;
      iorq_q    <= 1'b1;
      mreq_q    <= 1'b1;
      rd_q      <= 1'b1;
      wr_q      <= 1'b1;
      busack_q  <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!busrq_n) begin
            state    <= S_HOLD;
            busack_q <= 1'b0;
          end else if (!fifo_empty) begin
            state   <= S_T1;
            op_q    <= head.op;
            addr_q  <= head.addr;
            wdata_q <= head.data;
            mreq_q  <= op_is_io(head.op);
            iorq_q  <= !op_is_io(head.op);
            rd_q    <= op_is_write(head.op);
          end
        end
        S_T1: begin
          state <= S_T2;
          wr_q  <= !op_is_write(op_q);
        end
        S_T2: begin
          if (buswait_n) begin
            state  <= S_T3;
            iorq_q <= 1'b1;
            mreq_q <= 1'b1;
            rd_q   <= 1'b1;
            wr_q   <= 1'b1;
            if (!op_is_write(op_q)) begin
              rsp_valid <= 1'b1;
              rsp_data  <= data_;
            end
          end
        end
        S_T3: begin
          state <= S_IDLE;
        end
        S_HOLD: begin
          if (busrq_n) begin
            state    <= S_IDLE;
            busack_q <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign master    = reset_n && busack_q;
  assign iorq_n_   = master ? iorq_q : 1'bz;
  assign mreq_n_   = master ? mreq_q : 1'bz;
  assign rd_n_     = master ? rd_q   : 1'bz;
  assign wr_n_     = master ? wr_q   : 1'bz;
  assign addr_     = master ? addr_q : {ADDR_WIDTH{1'bz}};
  assign data_     = (master && !wr_q) ? wdata_q : {DATA_WIDTH{1'bz}};
  assign busack_n_ = reset_n ? busack_q : 1'bz;

endmodule

// File: tb/tb_bus_seq_master.sv
// tb/tb_bus_seq_master.sv - directed scoreboard bench for bus_seq_master
module tb_bus_seq_master;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_data;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        idle;
  tri1         iorq_n_;
  tri1         mreq_n_;
  tri1         rd_n_;
  tri1         wr_n_;
  tri1  [15:0] addr_;
  wire  [7:0]  data_;
  logic        buswait_n;
  logic        busrq_n;
  tri0         busack_n_;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int push_cyc;

  logic [7:0]  mem [0:65535];
  logic        poke_en;
  logic [15:0] poke_addr;
  logic [7:0]  poke_val;

  logic [7:0]  rsp_q [$];
  logic [24:0] wr_q [$];
  int          starts [$];
  int          lows [$];
  int          start_c = 0;
  logic        prev_low = 1'b0;
  logic        prev_wr = 1'b1;
  logic        mon_low;
  logic [7:0]  exp_rd;
  logic [24:0] exp_wr;

  bus_seq_master #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .CMD_DEPTH(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .idle      (idle),
    .iorq_n_   (iorq_n_),
    .mreq_n_   (mreq_n_),
    .rd_n_     (rd_n_),
    .wr_n_     (wr_n_),
    .addr_     (addr_),
    .data_     (data_),
    .buswait_n (buswait_n),
    .busrq_n   (busrq_n),
    .busack_n_ (busack_n_)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (poke_en) mem[poke_addr] <= poke_val;
    else if (reset_n && !mreq_n_ && !wr_n_) mem[addr_] <= data_;
  end

  assign data_ = (reset_n && !mreq_n_ && !rd_n_) ? mem[addr_] : 8'bz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (rsp_valid) begin
        compared++;
        assert (rsp_q.size() > 0) else begin
          mismatched++;
          $error("FAIL rsp_unexpected: observed rsp_valid with data %0h expected no response", rsp_data);
        end
        if (rsp_q.size() > 0) begin
          exp_rd = rsp_q.pop_front();
          chk("rsp_data", {24'd0, rsp_data}, {24'd0, exp_rd});
        end
      end
      mon_low = !mreq_n_ || !iorq_n_;
      if (mon_low && !prev_low) begin
        starts.push_back(cyc);
        start_c = cyc;
      end
      if (!mon_low && prev_low) lows.push_back(cyc - start_c);
      if (!wr_n_ && prev_wr) begin
        compared++;
        assert (wr_q.size() > 0) else begin
          mismatched++;
          $error("FAIL wr_unexpected: observed write of %0h expected none", data_);
        end
        if (wr_q.size() > 0) begin
          exp_wr = wr_q.pop_front();
          chk("wr_addr", {16'd0, addr_}, {16'd0, exp_wr[23:8]});
          chk("wr_data", {24'd0, data_}, {24'd0, exp_wr[7:0]});
          chk("wr_iorq_n", {31'd0, iorq_n_}, {31'd0, !exp_wr[24]});
          chk("wr_mreq_n", {31'd0, mreq_n_}, {31'd0, exp_wr[24]});
        end
      end
      prev_low = mon_low;
      prev_wr  = wr_n_;
    end else begin
      prev_low = 1'b0;
      prev_wr  = 1'b1;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] v);
    poke_en   = 1'b1;
    poke_addr = a;
    poke_val  = v;
    @(posedge clk);
    #1;
    poke_en = 1'b0;
  endtask

  task automatic push(input logic [1:0] op, input logic [15:0] a, input logic [7:0] d);
    int k = 0;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_data  = d;
    cmd_valid = 1'b1;
    while (!cmd_ready && k < 100) begin
      step();
      k++;
    end
    chk("push_ready", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk);
    #1;
    push_cyc  = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_starts(input int n, input string tag);
    int k = 0;
    while (starts.size() < n && k < 200) begin
      step();
      k++;
    end
    chk(tag, {31'd0, starts.size() >= n}, 32'd1);
  endtask

  task automatic wait_lows(input int n, input string tag);
    int k = 0;
    while (lows.size() < n && k < 300) begin
      step();
      k++;
    end
    chk(tag, {31'd0, lows.size() >= n}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int l0;
    int c;
    int ns;
    logic [7:0] hello [5];
    hello[0] = "H"; hello[1] = "e"; hello[2] = "l"; hello[3] = "l"; hello[4] = "o";

    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_addr  = 16'h0;
    cmd_data  = 8'h0;
    buswait_n = 1'b1;
    busrq_n   = 1'b1;
    poke_en   = 1'b0;
    poke_addr = 16'h0;
    poke_val  = 8'h0;
    repeat (3) step();

    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_idle", {31'd0, idle}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_data", {24'd0, rsp_data}, 32'd0);
    chk("rst_addr_z", {16'd0, addr_}, 32'hFFFF);
    chk("rst_busack_z", {31'd0, busack_n_}, 32'd0);

    reset_n = 1'b1;
    step();
    chk("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("post_rst_idle", {31'd0, idle}, 32'd1);
    chk("post_rst_busack", {31'd0, busack_n_}, 32'd1);
    chk("post_rst_addr", {16'd0, addr_}, 32'h0000);

    poke(16'h8000, 8'h5A);
    step();

    // MEM_WR then MEM_RD of the same location, back to back
    n0 = starts.size();
    l0 = lows.size();
    wr_q.push_back({1'b0, 16'h0001, 8'h99});
    push(2'd1, 16'h0001, 8'h99);
    c = push_cyc;
    rsp_q.push_back(8'h99);
    push(2'd0, 16'h0001, 8'h00);
    wait_lows(l0 + 2, "t1_done");
    chk("t1_first_start", starts[n0], c + 1);
    chk("t1_gap", starts[n0+1] - starts[n0], 32'd4);
    chk("t1_wr_len", lows[l0] + 1, 32'd3);
    chk("t1_rd_len", lows[l0+1] + 1, 32'd3);
    step();
    step();
    chk("t1_idle", {31'd0, idle}, 32'd1);

    // Read stretched by three wait cycles; memory changes during the wait
    n0 = starts.size();
    l0 = lows.size();
    buswait_n = 1'b0;
    rsp_q.push_back(8'hC3);
    push(2'd0, 16'h8000, 8'h00);
    wait_starts(n0 + 1, "t2_start");
    repeat (2) step();
    poke(16'h8000, 8'hC3);
    step();
    step();
    buswait_n = 1'b1;
    wait_lows(l0 + 1, "t2_done");
    chk("t2_len", lows[l0] + 1, 32'd6);
    repeat (2) step();

    // Bus held by an external requester while the FIFO fills
    busrq_n = 1'b0;
    step();
    chk("t3_busack_low", {31'd0, busack_n_}, 32'd0);
    chk("t3_addr_z", {16'd0, addr_}, 32'hFFFF);
    n0 = starts.size();
    for (int i = 0; i < 4; i++) begin
      wr_q.push_back({1'b0, 16'h0010 + 16'(i), 8'hA0 + 8'(i)});
      push(2'd1, 16'h0010 + 16'(i), 8'hA0 + 8'(i));
    end
    step();
    chk("t3_full_ready", {31'd0, cmd_ready}, 32'd0);
    cmd_op = 2'd0; cmd_addr = 16'h0012; cmd_valid = 1'b1;
    repeat (2) step();
    chk("t3_still_full", {31'd0, cmd_ready}, 32'd0);
    cmd_valid = 1'b0;
    chk("t3_no_start_in_hold", starts.size(), n0);
    busrq_n = 1'b1;
    c = cyc;
    step();
    chk("t3_busack_high", {31'd0, busack_n_}, 32'd1);
    wait_starts(n0 + 4, "t3_drain");
    chk("t3_first_start", starts[n0], c + 2);
    for (int i = 1; i < 4; i++) chk("t3_gap", starts[n0+i] - starts[n0+i-1], 32'd4);
    repeat (6) step();
    chk("t3_exact_four", starts.size(), n0 + 4);
    rsp_q.push_back(8'hA2);
    push(2'd0, 16'h0012, 8'h00);
    wait_starts(n0 + 5, "t3_readback");
    repeat (4) step();

    // Bus request arriving while a read sits in T2
    n0 = starts.size();
    l0 = lows.size();
    buswait_n = 1'b0;
    rsp_q.push_back(8'h99);
    push(2'd0, 16'h0001, 8'h00);
    wait_starts(n0 + 1, "t4_start");
    step();
    busrq_n = 1'b0;
    step();
    buswait_n = 1'b1;
    step();
    step();
    chk("t4_busack_idle", {31'd0, busack_n_}, 32'd1);
    step();
    chk("t4_busack_low", {31'd0, busack_n_}, 32'd0);
    chk("t4_addr_z", {16'd0, addr_}, 32'hFFFF);
    chk("t4_len", lows[l0] + 1, 32'd4);
    busrq_n = 1'b1;
    step();
    chk("t4_busack_back", {31'd0, busack_n_}, 32'd1);
    step();

    // IO writes spelling Hello
    l0 = lows.size();
    for (int i = 0; i < 5; i++) begin
      wr_q.push_back({1'b1, 16'h0000, hello[i]});
      push(2'd3, 16'h0000, hello[i]);
    end
    wait_lows(l0 + 5, "t5_done");
    step();

    // Reset in the middle of a read with another command queued
    n0 = starts.size();
    buswait_n = 1'b0;
    push(2'd0, 16'h0001, 8'h00);
    push(2'd0, 16'h0001, 8'h00);
    wait_starts(n0 + 1, "t6_start");
    step();
    reset_n = 1'b0;
    step();
    chk("t6_addr_z", {16'd0, addr_}, 32'hFFFF);
    chk("t6_busack_z", {31'd0, busack_n_}, 32'd0);
    chk("t6_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("t6_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    reset_n = 1'b1;
    buswait_n = 1'b1;
    step();
    chk("t6_idle", {31'd0, idle}, 32'd1);
    chk("t6_cmd_ready_back", {31'd0, cmd_ready}, 32'd1);
    ns = starts.size();
    repeat (8) step();
    chk("t6_flushed", starts.size(), ns);

    chk("rsp_queue_drained", rsp_q.size(), 32'd0);
    chk("wr_queue_drained", wr_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
